// File: rtl/dac_spi_frame_rx_if.sv
// dac_spi_frame_rx_if: SPI line inputs plus frame handshake and status for the DAC link receiver.
interface dac_spi_frame_rx_if #(
   parameter int FrameBits = 24
);
   logic                 dac_sclk_i;
   logic                 dac_mosi_i;
   logic                 dac_sync_ni;
   logic                 frame_ready_i;
   logic                 clear_i;
   logic [FrameBits-1:0] frame_data_o;
   logic                 frame_valid_o;
   logic                 short_err_o;
   logic                 long_err_o;
   logic                 overrun_o;
   logic                 busy_o;
   modport slave (
      input  dac_sclk_i, dac_mosi_i, dac_sync_ni, frame_ready_i, clear_i,
      output frame_data_o, frame_valid_o, short_err_o, long_err_o, overrun_o, busy_o
   );
   modport master (
      output dac_sclk_i, dac_mosi_i, dac_sync_ni, frame_ready_i, clear_i,
      input  frame_data_o, frame_valid_o, short_err_o, long_err_o, overrun_o, busy_o
   );
endinterface

// File: rtl/dac_spi_frame_rx.sv
// dac_spi_frame_rx: oversampling SPI peripheral receiver, sync_n-framed MSB-first words onto valid/ready.
module dac_spi_frame_rx #(
   parameter int FrameBits       = 24,
   parameter bit SampleOnFalling = 1'b1
) (
   input logic                 clk_i,
   input logic                 reset_i,
   dac_spi_frame_rx_if.slave   bus
);
   localparam int CW = $clog2(FrameBits + 2);
   localparam logic [CW-1:0] CntFull = CW'(FrameBits);
   localparam logic [CW-1:0] CntSat  = CW'(FrameBits + 1);
   typedef enum logic [1:0] {ARM, IDLE, SHIFT, FEND} state_e;
   state_e               state_q, state_d;
   logic [2:0]           sclk_q, sclk_d, sync_q, sync_d;
   logic [1:0]           mosi_q, mosi_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [FrameBits-1:0] shift_q, shift_d, data_q, data_d;
   logic                 valid_q, valid_d, short_q, short_d, long_q, long_d, ovr_q, ovr_d;
   logic                 sclk_edge, sync_fall, sync_rise;
   // [1] is the settled sample, [2] its one-cycle history for edge detection
   assign sclk_edge = SampleOnFalling ? (sclk_q[2] & ~sclk_q[1]) : (~sclk_q[2] & sclk_q[1]);
   assign sync_fall = sync_q[2] & ~sync_q[1];
   assign sync_rise = ~sync_q[2] & sync_q[1];
   always_comb begin
      sclk_d  = {sclk_q[1:0], bus.dac_sclk_i};
      sync_d  = {sync_q[1:0], bus.dac_sync_ni};
      mosi_d  = {mosi_q[0], bus.dac_mosi_i};
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q & ~bus.frame_ready_i;
      short_d = 1'b0;
      long_d  = 1'b0;
      ovr_d   = ovr_q & ~bus.clear_i;
      case (state_q)
         ARM:   state_d = sync_q[1] ? IDLE : ARM;
         IDLE: begin
            if (sync_fall) begin
               state_d = SHIFT;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         SHIFT: begin
            if (sync_rise) begin
               state_d = FEND;
            end else if (sclk_edge && cnt_q != CntSat) begin
               shift_d = {shift_q[FrameBits-2:0], mosi_q[1]};
               cnt_d   = cnt_q + CW'(1);
            end
         end
         FEND: begin
            state_d = IDLE;
            short_d = cnt_q < CntFull;
            long_d  = cnt_q > CntFull;
            if (cnt_q == CntFull) begin
               if (!valid_q || bus.frame_ready_i) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
         end
         default: state_d = ARM;
      endcase
   end
   // sync_n history resets low so a frame already open at reset release is never captured
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= ARM;
         sclk_q  <= '0;
         sync_q  <= '0;
         mosi_q  <= '0;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sclk_q  <= sclk_d;
         sync_q  <= sync_d;
         mosi_q  <= mosi_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         short_q <= short_d;
         long_q  <= long_d;
         ovr_q   <= ovr_d;
      end
   end
   assign bus.frame_data_o  = data_q;
   assign bus.frame_valid_o = valid_q;
   assign bus.short_err_o   = short_q;
   assign bus.long_err_o    = long_q;
   assign bus.overrun_o     = ovr_q;
   assign bus.busy_o        = state_q == SHIFT;
endmodule

// File: tb/tb_dac_spi_frame_rx.sv
// tb_dac_spi_frame_rx: directed frames against a falling-edge receiver and a rising-edge receiver.
module tb_dac_spi_frame_rx;
   logic clk_i = 1'b0, reset_i = 1'b0;
   logic sclk = 1'b0, mosi = 1'b0, sync_n = 1'b1, ready = 1'b0, clear = 1'b0, mode = 1'b1;
   int vec = 0, bad = 0;
   int acc_cnt = 0, short_cnt = 0, long_cnt = 0, busy_cnt = 0;
   logic [23:0] acc_prev = '0, acc_last = '0;
   always #5 clk_i = ~clk_i;
   dac_spi_frame_rx_if #(.FrameBits(24)) a ();
   dac_spi_frame_rx_if #(.FrameBits(24)) b ();
   assign a.dac_sclk_i    = mode ? sclk : 1'b0;
   assign a.dac_sync_ni   = mode ? sync_n : 1'b1;
   assign a.dac_mosi_i    = mosi;
   assign a.frame_ready_i = ready;
   assign a.clear_i       = clear;
   assign b.dac_sclk_i    = mode ? 1'b0 : sclk;
   assign b.dac_sync_ni   = mode ? 1'b1 : sync_n;
   assign b.dac_mosi_i    = mosi;
   assign b.frame_ready_i = ready;
   assign b.clear_i       = clear;
   dac_spi_frame_rx #(.FrameBits(24), .SampleOnFalling(1'b1)) u_fall (.clk_i(clk_i), .reset_i(reset_i), .bus(a));
   dac_spi_frame_rx #(.FrameBits(24), .SampleOnFalling(1'b0)) u_rise (.clk_i(clk_i), .reset_i(reset_i), .bus(b));
   wire [23:0] m_data  = mode ? a.frame_data_o  : b.frame_data_o;
   wire        m_valid = mode ? a.frame_valid_o : b.frame_valid_o;
   wire        m_short = mode ? a.short_err_o   : b.short_err_o;
   wire        m_long  = mode ? a.long_err_o    : b.long_err_o;
   wire        m_ovr   = mode ? a.overrun_o     : b.overrun_o;
   wire        m_busy  = mode ? a.busy_o        : b.busy_o;
   // inputs only change on negedges, so sampling here sees the settled result of the last posedge
   always @(negedge clk_i) begin
      if (m_valid && ready) begin
         acc_prev = acc_last;
         acc_last = m_data;
         acc_cnt++;
      end
      if (m_short) short_cnt++;
      if (m_long) long_cnt++;
      if (m_busy) busy_cnt++;
   end
   task automatic shift_bits(input logic [31:0] d, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         if (mode) begin
            sclk = 1'b1; mosi = d[i]; #40; sclk = 1'b0; #40;
         end else begin
            mosi = d[i]; #40; sclk = 1'b1; #40; sclk = 1'b0;
         end
      end
   endtask
   task automatic frame(input logic [31:0] d, input int n, input bit lat, input bit pulse);
      sync_n = 1'b0; #80;
      shift_bits(d, n); #40;
      sync_n = 1'b1; #30;
      if (lat) begin
         vec++; if (m_valid !== 1'b0) begin bad++; $display("FAIL latency_early: valid %b exp 0", m_valid); end
      end
      #10;
      if (lat) begin
         vec++; if (m_valid !== 1'b1) begin bad++; $display("FAIL latency_4th_edge: valid %b exp 1", m_valid); end
      end
      if (pulse) ready = 1'b1;
      #10;
      if (pulse) ready = 1'b0;
      #110;
   endtask
   task automatic test_reset();
      reset_i = 1'b0; #40;
      vec++; if (a.frame_data_o !== 24'h0) begin bad++; $display("FAIL reset_data: got %h exp 000000", a.frame_data_o); end
      vec++; if (a.frame_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", a.frame_valid_o); end
      vec++; if (a.short_err_o !== 1'b0) begin bad++; $display("FAIL reset_short: got %b exp 0", a.short_err_o); end
      vec++; if (a.long_err_o !== 1'b0) begin bad++; $display("FAIL reset_long: got %b exp 0", a.long_err_o); end
      vec++; if (a.overrun_o !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b exp 0", a.overrun_o); end
      vec++; if (a.busy_o !== 1'b0 || b.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b%b exp 00", a.busy_o, b.busy_o); end
      reset_i = 1'b1; #40;
   endtask
   task automatic test_basic();
      int a0, s0, l0, b0;
      a0 = acc_cnt; s0 = short_cnt; l0 = long_cnt; b0 = busy_cnt;
      ready = 1'b1;
      frame(32'hA5C3F0, 24, 1'b1, 1'b0);
      vec++; if (acc_cnt - a0 !== 1) begin bad++; $display("FAIL basic_count: got %0d exp 1", acc_cnt - a0); end
      vec++; if (acc_last !== 24'hA5C3F0) begin bad++; $display("FAIL basic_data: got %h exp a5c3f0", acc_last); end
      vec++; if (short_cnt - s0 !== 0 || long_cnt - l0 !== 0) begin bad++; $display("FAIL basic_err: got %0d/%0d exp 0/0", short_cnt - s0, long_cnt - l0); end
      vec++; if (busy_cnt - b0 !== 204) begin bad++; $display("FAIL basic_busy_cycles: got %0d exp 204", busy_cnt - b0); end
      vec++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_consumed: valid %b exp 0", m_valid); end
   endtask
   task automatic test_overrun();
      ready = 1'b0;
      frame(32'h123456, 24, 1'b1, 1'b0);
      frame(32'h654321, 24, 1'b0, 1'b0);
      vec++; if (m_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b exp 1", m_valid); end
      vec++; if (m_data !== 24'h123456) begin bad++; $display("FAIL ovr_data: got %h exp 123456", m_data); end
      vec++; if (m_ovr !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b exp 1", m_ovr); end
      clear = 1'b1; #10; clear = 1'b0; #10;
      vec++; if (m_ovr !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b exp 0", m_ovr); end
      vec++; if (m_valid !== 1'b1 || m_data !== 24'h123456) begin bad++; $display("FAIL ovr_hold: got %b %h exp 1 123456", m_valid, m_data); end
      ready = 1'b1; #10; ready = 1'b0;
      vec++; if (m_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: valid %b exp 0", m_valid); end
   endtask
   task automatic test_short_long();
      int a0, s0, l0;
      ready = 1'b1;
      a0 = acc_cnt; s0 = short_cnt; l0 = long_cnt;
      frame(32'hBEEF, 16, 1'b0, 1'b0);
      vec++; if (short_cnt - s0 !== 1) begin bad++; $display("FAIL short_pulse: got %0d exp 1", short_cnt - s0); end
      vec++; if (acc_cnt - a0 !== 0 || m_valid !== 1'b0) begin bad++; $display("FAIL short_novalid: got %0d exp 0", acc_cnt - a0); end
      vec++; if (long_cnt - l0 !== 0) begin bad++; $display("FAIL short_nolong: got %0d exp 0", long_cnt - l0); end
      a0 = acc_cnt; s0 = short_cnt; l0 = long_cnt;
      frame(32'h2AAAAAAA, 30, 1'b0, 1'b0);
      vec++; if (long_cnt - l0 !== 1) begin bad++; $display("FAIL long_pulse: got %0d exp 1", long_cnt - l0); end
      vec++; if (short_cnt - s0 !== 0) begin bad++; $display("FAIL long_noshort: got %0d exp 0", short_cnt - s0); end
      vec++; if (acc_cnt - a0 !== 0 || m_valid !== 1'b0) begin bad++; $display("FAIL long_novalid: got %0d exp 0", acc_cnt - a0); end
   endtask
   task automatic test_reset_mid();
      int a0, s0, l0;
      ready = 1'b1;
      a0 = acc_cnt; s0 = short_cnt; l0 = long_cnt;
      sync_n = 1'b0; #80;
      shift_bits(32'hABC, 12);
      reset_i = 1'b0; #40; reset_i = 1'b1;
      shift_bits(32'hDEF, 12); #40;
      sync_n = 1'b1; #160;
      vec++; if (acc_cnt - a0 !== 0) begin bad++; $display("FAIL midreset_noframe: got %0d exp 0", acc_cnt - a0); end
      vec++; if (short_cnt - s0 !== 0 || long_cnt - l0 !== 0) begin bad++; $display("FAIL midreset_noerr: got %0d/%0d exp 0/0", short_cnt - s0, long_cnt - l0); end
      frame(32'h000001, 24, 1'b1, 1'b0);
      vec++; if (acc_cnt - a0 !== 1) begin bad++; $display("FAIL midreset_next_count: got %0d exp 1", acc_cnt - a0); end
      vec++; if (acc_last !== 24'h000001) begin bad++; $display("FAIL midreset_next_data: got %h exp 000001", acc_last); end
   endtask
   task automatic test_back_to_back();
      int a0;
      ready = 1'b0;
      a0 = acc_cnt;
      frame(32'hFFFFFF, 24, 1'b1, 1'b1);
      frame(32'h000000, 24, 1'b1, 1'b1);
      vec++; if (acc_cnt - a0 !== 2) begin bad++; $display("FAIL b2b_count: got %0d exp 2", acc_cnt - a0); end
      vec++; if (acc_prev !== 24'hFFFFFF) begin bad++; $display("FAIL b2b_first: got %h exp ffffff", acc_prev); end
      vec++; if (acc_last !== 24'h000000) begin bad++; $display("FAIL b2b_second: got %h exp 000000", acc_last); end
      vec++; if (m_ovr !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL b2b_state: ovr %b valid %b exp 0 0", m_ovr, m_valid); end
   endtask
   task automatic test_rising();
      mode = 1'b0; ready = 1'b0; #160;
      frame(32'h800001, 24, 1'b1, 1'b0);
      vec++; if (m_data !== 24'h800001) begin bad++; $display("FAIL rise_data: got %h exp 800001", m_data); end
      ready = 1'b1; #10; ready = 1'b0;
      vec++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rise_consumed: valid %b exp 0", m_valid); end
      vec++; if (a.frame_valid_o !== 1'b0) begin bad++; $display("FAIL rise_other_idle: valid %b exp 0", a.frame_valid_o); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_short_long();
      test_reset_mid();
      test_back_to_back();
      test_rising();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
